// File: rtl/denise_bitplane_sequencer.sv
// -----------------------------------------------------------------------------
// denise_bitplane_sequencer
//
// Raw bitplane datapath in front of the playfield engine. Bitplane data
// register writes are captured in per-plane holding registers. A write to
// plane 1 arms a load. On the next pixel slot, every holding register is
// copied into its parallel-to-serial shifter. From then on, each pixel slot
// emits one bit per plane. That bit is delayed by the per-playfield scroll
// value, masked by the enabled plane count and the display window, and
// registered onto bpldata.
//
// Ports
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   pix_en    in   pixel strobe, one pulse per output pixel
//   reg_wr    in   bitplane data register write strobe
//   reg_sel   in   [2:0]  plane index of the write (0 = plane 1 .. 7 = plane 8)
//   reg_data  in   [15:0] write data, bit 15 is the leftmost pixel
//   pf1h      in   [3:0]  scroll delay for odd planes 1,3,5,7
//   pf2h      in   [3:0]  scroll delay for even planes 2,4,6,8
//   bpu       in   [3:0]  enabled plane count (9..15 behave as 8)
//   disp_en   in   display window active
//   bpldata   out  [7:0]  serial pixel data, bit n-1 = plane n
//   loaded    out  pulses high for one cycle after each load
//   empty     out  high once 16 pixels have been shifted since the last load
// -----------------------------------------------------------------------------
module denise_bitplane_sequencer #(
    parameter int NPL   = 8,
    parameter int DLY_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_en,
    input  logic             reg_wr,
    input  logic [2:0]       reg_sel,
    input  logic [15:0]      reg_data,
    input  logic [DLY_W-1:0] pf1h,
    input  logic [DLY_W-1:0] pf2h,
    input  logic [3:0]       bpu,
    input  logic             disp_en,
    output logic [NPL-1:0]   bpldata,
    output logic             loaded,
    output logic             empty
);

    localparam logic [4:0] CNT_FULL = 5'd16;

    logic [15:0]    hold_q  [NPL];
    logic [15:0]    hold_d  [NPL];
    logic [15:0]    shift_q [NPL];
    logic [15:0]    shift_d [NPL];
    logic [15:0]    hist_q  [NPL];
    logic [15:0]    hist_d  [NPL];
    logic           arm_q, arm_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [NPL-1:0] bpl_q, bpl_d;
    logic           loaded_q;
    logic           empty_q;

    logic           load;
    logic [NPL-1:0] ser;
    logic [NPL-1:0] tap;
    logic [NPL-1:0] plane_on;

    // The arm flag must already be set before this edge. A plane-1 write
    // arriving on the same edge only re-arms the next load.
    assign load = pix_en & arm_q;

    for (genvar p = 0; p < NPL; p++) begin : g_plane
        logic [DLY_W-1:0] dly;

        // Index 0 is plane 1, so even indices are the odd (playfield 1) planes.
        assign dly         = (p % 2 == 0) ? pf1h : pf2h;
        assign ser[p]      = shift_q[p][15];
        // When dly is 0, the history index wraps to 15, but the mux discards it.
        assign tap[p]      = (dly == '0) ? ser[p] : hist_q[p][dly - 1'b1];
        assign plane_on[p] = ({1'b0, bpu} > 5'(p));
    end

    // NOTE: every variable gets a default at the top of the block, so paths
    // that do not assign it hold the old value and no latch is inferred.
    always_comb begin
        hold_d  = hold_q;
        shift_d = shift_q;
        hist_d  = hist_q;
        arm_d   = arm_q;
        cnt_d   = cnt_q;
        bpl_d   = bpl_q;

        if (reg_wr) begin
            hold_d[reg_sel] = reg_data;
        end

        // Setting the arm flag wins over clearing it, so a plane-1 write on
        // the load slot queues another load.
        if (reg_wr && (reg_sel == 3'd0)) begin
            arm_d = 1'b1;
        end else if (load) begin
            arm_d = 1'b0;
        end

        // A load replaces the shift. It copies hold_q, which holds the data
        // from before this edge's write.
        if (load) begin
            shift_d = hold_q;
            cnt_d   = '0;
        end else if (pix_en) begin
            for (int p = 0; p < NPL; p++) begin
                shift_d[p] = {shift_q[p][14:0], 1'b0};
            end
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + 5'd1;
            end
        end

        // Histories keep running while the output is masked, so scrolled data
        // stays continuous across the edge of the display window.
        if (pix_en) begin
            for (int p = 0; p < NPL; p++) begin
                hist_d[p] = {hist_q[p][14:0], ser[p]};
            end
            bpl_d = tap & plane_on & {NPL{disp_en}};
        end
    end

    // NOTE: the holding, shift and history arrays are cleared by reset.
    // They are therefore built as flops, not as a RAM macro.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q   <= '{default: '0};
            shift_q  <= '{default: '0};
            hist_q   <= '{default: '0};
            arm_q    <= 1'b0;
            cnt_q    <= CNT_FULL;
            bpl_q    <= '0;
            loaded_q <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here, so every register updates
            // from pre-edge values no matter how the statements are ordered.
            hold_q   <= hold_d;
            shift_q  <= shift_d;
            hist_q   <= hist_d;
            arm_q    <= arm_d;
            cnt_q    <= cnt_d;
            bpl_q    <= bpl_d;
            loaded_q <= load;
            empty_q  <= (cnt_d == CNT_FULL);
        end
    end

    assign bpldata = bpl_q;
    assign loaded  = loaded_q;
    assign empty   = empty_q;

endmodule
